ddr3_rd_arbiter: RTL and testbench

- Two-master round-robin arbiter for the read path of the DDR3 AXI slave. It shares one slave read address and read data channel pair between master 0 and master 1.
- It grants one master per burst. It forwards that master's AR transaction, then routes the returned R beats to it until the LAST beat completes the handshake.
- It sits between the bus interconnect and the DDR3 slave. It runs on the slave-provided clock.

---
 rtl/ddr3_rd_arbiter_pkg.sv | 17 +
 rtl/ddr3_rd_arbiter_if.sv | 37 +++
 rtl/ddr3_rd_arbiter_rr_arb2.sv | 19 +
 rtl/ddr3_rd_arbiter.sv | 146 ++++++++++++++
 tb/tb_ddr3_rd_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr3_rd_arbiter_pkg.sv
// Shared types and constants for the two-master DDR3 read-path arbiter.
package ddr3_rd_arbiter_pkg;

  localparam int ID_W_DEF   = 4;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ddr3_rd_arbiter_if.sv
// AXI read address + read data channel pair; master drives AR and R READY.
interface ddr3_rd_arbiter_if
  import ddr3_rd_arbiter_pkg::*;
#(
  parameter int ID_W   = ID_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [ID_W-1:0]   RD_ADDR_ID;
  logic [ADDR_W-1:0] RD_ADDR;
  logic [7:0]        RD_ADDR_LEN;
  logic [1:0]        RD_ADDR_BURST;
  logic              RD_ADDR_VALID;
  logic              RD_ADDR_READY;

  logic [ID_W-1:0]   RD_BACK_ID;
  logic [DATA_W-1:0] RD_DATA;
  logic [1:0]        RD_DATA_RESP;
  logic              RD_DATA_LAST;
  logic              RD_DATA_VALID;
  logic              RD_DATA_READY;

  modport master (
    output RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_BURST, RD_ADDR_VALID,
    input  RD_ADDR_READY,
    input  RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID,
    output RD_DATA_READY
  );

  modport slave (
    input  RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_BURST, RD_ADDR_VALID,
    output RD_ADDR_READY,
    output RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID,
    input  RD_DATA_READY
  );

endinterface

// File: rtl/ddr3_rd_arbiter_rr_arb2.sv
// Combinational 2-way round-robin pick; the last-grant pointer lives in the caller.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_gnt,
  output logic       o_gnt_valid
);

  always_comb begin
    o_gnt_valid = |i_req;
    case (i_req)
      2'b01:   o_gnt = 1'b0;
      2'b10:   o_gnt = 1'b1;
      2'b11:   o_gnt = ~i_last_grant;
      default: o_gnt = i_last_grant;
    endcase
  end

endmodule

// File: rtl/ddr3_rd_arbiter.sv
// Two-master round-robin arbiter sharing one DDR3 AXI read channel pair.
// One grant per burst: forward the AR, then route R beats until LAST.
module ddr3_rd_arbiter
  import ddr3_rd_arbiter_pkg::*;
#(
  parameter int ID_W   = ID_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  ddr3_rd_arbiter_if.slave  m0,
  ddr3_rd_arbiter_if.slave  m1,
  ddr3_rd_arbiter_if.master s,
  output logic              grant_o,
  output logic              busy_o,
  output logic              proto_err
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_grant;
  logic [8:0]        r_beat_cnt;
  logic [7:0]        r_len_q;
  logic              r_proto_err;

  logic              w_arb_gnt;
  logic              w_arb_valid;
  logic [ID_W-1:0]   w_ar_id;
  logic [ADDR_W-1:0] w_ar_addr;
  logic [7:0]        w_ar_len;
  logic [1:0]        w_ar_burst;
  logic              w_ar_valid;
  logic              w_ar_hs;
  logic [ID_W-1:0]   w_r_id;
  logic [DATA_W-1:0] w_r_data;
  logic              w_gnt_rready;
  logic              w_r_hs;
  logic              w_r_err;

  rr_arb2 u_rr_arb2 (
    .i_req        ({m1.RD_ADDR_VALID, m0.RD_ADDR_VALID}),
    .i_last_grant (r_grant),
    .o_gnt        (w_arb_gnt),
    .o_gnt_valid  (w_arb_valid)
  );

  assign w_ar_id      = r_grant ? m1.RD_ADDR_ID    : m0.RD_ADDR_ID;
  assign w_ar_addr    = r_grant ? m1.RD_ADDR       : m0.RD_ADDR;
  assign w_ar_len     = r_grant ? m1.RD_ADDR_LEN   : m0.RD_ADDR_LEN;
  assign w_ar_burst   = r_grant ? m1.RD_ADDR_BURST : m0.RD_ADDR_BURST;
  assign w_ar_valid   = r_grant ? m1.RD_ADDR_VALID : m0.RD_ADDR_VALID;
  assign w_gnt_rready = r_grant ? m1.RD_DATA_READY : m0.RD_DATA_READY;
  assign w_r_id       = s.RD_BACK_ID;
  assign w_r_data     = s.RD_DATA;

  assign w_ar_hs = (r_state == ADDR) && w_ar_valid && s.RD_ADDR_READY;
  assign w_r_hs  = (r_state == DATA) && s.RD_DATA_VALID && w_gnt_rready;
  // A burst is well formed only if LAST lands exactly on beat index LEN.
  assign w_r_err = s.RD_DATA_LAST ? (r_beat_cnt != {1'b0, r_len_q})
                                  : (r_beat_cnt == {1'b0, r_len_q});

  // NOTE: every output is defaulted before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    s.RD_ADDR_ID     = '0;
    s.RD_ADDR        = '0;
    s.RD_ADDR_LEN    = '0;
    s.RD_ADDR_BURST  = '0;
    s.RD_ADDR_VALID  = 1'b0;
    s.RD_DATA_READY  = 1'b0;
    m0.RD_ADDR_READY = 1'b0;
    m0.RD_BACK_ID    = '0;
    m0.RD_DATA       = '0;
    m0.RD_DATA_RESP  = '0;
    m0.RD_DATA_LAST  = 1'b0;
    m0.RD_DATA_VALID = 1'b0;
    m1.RD_ADDR_READY = 1'b0;
    m1.RD_BACK_ID    = '0;
    m1.RD_DATA       = '0;
    m1.RD_DATA_RESP  = '0;
    m1.RD_DATA_LAST  = 1'b0;
    m1.RD_DATA_VALID = 1'b0;
    // Reset silences every handshake in the same cycle it is asserted.
    if (!rst) begin
      case (r_state)
        IDLE: if (w_arb_valid) w_state_nxt = ADDR;
        ADDR: begin
          s.RD_ADDR_ID    = w_ar_id;
          s.RD_ADDR       = w_ar_addr;
          s.RD_ADDR_LEN   = w_ar_len;
          s.RD_ADDR_BURST = w_ar_burst;
          s.RD_ADDR_VALID = w_ar_valid;
          if (r_grant) m1.RD_ADDR_READY = s.RD_ADDR_READY;
          else         m0.RD_ADDR_READY = s.RD_ADDR_READY;
          if (w_ar_hs) w_state_nxt = DATA;
        end
        DATA: begin
          s.RD_DATA_READY = w_gnt_rready;
          if (r_grant) begin
            m1.RD_BACK_ID    = w_r_id;
            m1.RD_DATA       = w_r_data;
            m1.RD_DATA_RESP  = s.RD_DATA_RESP;
            m1.RD_DATA_LAST  = s.RD_DATA_LAST;
            m1.RD_DATA_VALID = s.RD_DATA_VALID;
          end else begin
            m0.RD_BACK_ID    = w_r_id;
            m0.RD_DATA       = w_r_data;
            m0.RD_DATA_RESP  = s.RD_DATA_RESP;
            m0.RD_DATA_LAST  = s.RD_DATA_LAST;
            m0.RD_DATA_VALID = s.RD_DATA_VALID;
          end
          if (w_r_hs && s.RD_DATA_LAST) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant     <= 1'b1;
      r_beat_cnt  <= '0;
      r_len_q     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_arb_valid) r_grant <= w_arb_gnt;
      if (w_ar_hs) begin
        r_len_q    <= w_ar_len;
        r_beat_cnt <= '0;
      end
      if (w_r_hs) begin
        r_beat_cnt <= r_beat_cnt + 9'd1;
        if (w_r_err) r_proto_err <= 1'b1;
      end
    end
  end

  assign grant_o   = r_grant;
  assign busy_o    = (r_state != IDLE);
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_ddr3_rd_arbiter.sv
// Randomized bench for ddr3_rd_arbiter: bus-level masters/slave plus a transaction model.
module tb_ddr3_rd_arbiter;
  import ddr3_rd_arbiter_pkg::*;

  localparam int P_IDLE = 0;
  localparam int P_ADDR = 1;
  localparam int P_DATA = 2;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [31:0] dseed;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  logic grant_o, busy_o, proto_err;

  ddr3_rd_arbiter_if m0_if ();
  ddr3_rd_arbiter_if m1_if ();
  ddr3_rd_arbiter_if s_if ();

  ddr3_rd_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .grant_o   (grant_o),
    .busy_o    (busy_o),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  logic [1:0]  arrdy, rvalid, rlast;
  logic [31:0] rdata [2];
  logic [3:0]  rid   [2];
  logic [1:0]  rresp [2];
  assign arrdy    = {m1_if.RD_ADDR_READY, m0_if.RD_ADDR_READY};
  assign rvalid   = {m1_if.RD_DATA_VALID, m0_if.RD_DATA_VALID};
  assign rlast    = {m1_if.RD_DATA_LAST,  m0_if.RD_DATA_LAST};
  assign rdata[0] = m0_if.RD_DATA;
  assign rdata[1] = m1_if.RD_DATA;
  assign rid[0]   = m0_if.RD_BACK_ID;
  assign rid[1]   = m1_if.RD_BACK_ID;
  assign rresp[0] = m0_if.RD_DATA_RESP;
  assign rresp[1] = m1_if.RD_DATA_RESP;

  int n_checks = 0;
  int n_fail   = 0;

  // Environment knobs and state
  req_t        m_req [2];
  logic        m_pend [2];
  logic        m_rrdy [2];
  int          rrdy_pct [2];
  int          arrdy_pct, rvalid_pct;
  logic        s_arrdy;
  int          force_beats;
  req_t        sl_req;
  logic        sl_active, sl_valid;
  logic [1:0]  sl_resp;
  int          sl_idx, sl_nbeats, sl_rx;
  // Transaction-level reference
  int          mdl_phase;
  logic        mdl_grant, mdl_err;
  int          rx_obs [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_phase = P_IDLE;
    mdl_grant = 1'b1;
    mdl_err   = 1'b0;
    m_pend[0] = 1'b0;
    m_pend[1] = 1'b0;
    sl_active = 1'b0;
    sl_valid  = 1'b0;
  endtask

  task automatic new_req(input int i, input logic [7:0] len, input logic [31:0] addr,
                         input logic [31:0] dseed);
    m_req[i].id    = 4'($urandom);
    m_req[i].addr  = addr;
    m_req[i].len   = len;
    m_req[i].burst = 2'($urandom_range(2));
    m_req[i].dseed = dseed;
    m_pend[i]      = 1'b1;
  endtask

  // One clock cycle: entered and left at a negedge; drive, settle, compare, advance model.
  task automatic step();
    int          g, og;
    logic        last;
    logic [31:0] exp_data;
    for (int i = 0; i < 2; i++) m_rrdy[i] = ($urandom_range(99) < rrdy_pct[i]);
    s_arrdy = ($urandom_range(99) < arrdy_pct);
    if (sl_active && !sl_valid && ($urandom_range(99) < rvalid_pct)) begin
      sl_valid = 1'b1;
      sl_resp  = ($urandom_range(3) == 0) ? RESP_SLVERR : RESP_OKAY;
    end
    m0_if.RD_ADDR_VALID = m_pend[0];
    m0_if.RD_ADDR_ID    = m_req[0].id;
    m0_if.RD_ADDR       = m_req[0].addr;
    m0_if.RD_ADDR_LEN   = m_req[0].len;
    m0_if.RD_ADDR_BURST = m_req[0].burst;
    m0_if.RD_DATA_READY = m_rrdy[0];
    m1_if.RD_ADDR_VALID = m_pend[1];
    m1_if.RD_ADDR_ID    = m_req[1].id;
    m1_if.RD_ADDR       = m_req[1].addr;
    m1_if.RD_ADDR_LEN   = m_req[1].len;
    m1_if.RD_ADDR_BURST = m_req[1].burst;
    m1_if.RD_DATA_READY = m_rrdy[1];
    last     = (sl_idx == sl_nbeats - 1);
    exp_data = sl_req.dseed + 32'(sl_idx);
    s_if.RD_ADDR_READY  = s_arrdy;
    s_if.RD_DATA_VALID  = sl_valid;
    s_if.RD_BACK_ID     = sl_req.id;
    s_if.RD_DATA        = exp_data;
    s_if.RD_DATA_RESP   = sl_resp;
    s_if.RD_DATA_LAST   = last;
    #1;
    check("grant_o", grant_o, mdl_grant);
    check("busy_o", busy_o, mdl_phase != P_IDLE);
    check("proto_err", proto_err, mdl_err);
    g  = int'(mdl_grant);
    og = 1 - g;
    case (mdl_phase)
      P_IDLE: begin
        check("idle_quiet", {s_if.RD_ADDR_VALID, s_if.RD_DATA_READY, arrdy, rvalid, s_if.RD_ADDR}, 0);
        if (m_pend[0] || m_pend[1]) begin
          if (m_pend[0] && m_pend[1]) mdl_grant = ~mdl_grant;
          else                        mdl_grant = m_pend[1];
          mdl_phase = P_ADDR;
        end
      end
      P_ADDR: begin
        check("ar_valid", s_if.RD_ADDR_VALID, m_pend[g]);
        check("ar_ready_gnt", arrdy[g], s_arrdy);
        check("addr_quiet", {arrdy[og], rvalid, s_if.RD_DATA_READY}, 0);
        if (m_pend[g]) begin
          check("ar_payload",
                {s_if.RD_ADDR_ID, s_if.RD_ADDR, s_if.RD_ADDR_LEN, s_if.RD_ADDR_BURST},
                {m_req[g].id, m_req[g].addr, m_req[g].len, m_req[g].burst});
          if (s_arrdy) begin
            m_pend[g] = 1'b0;
            sl_req    = m_req[g];
            sl_nbeats = (force_beats > 0) ? force_beats : int'(m_req[g].len) + 1;
            sl_idx    = 0;
            sl_rx     = 0;
            sl_active = 1'b1;
            sl_valid  = 1'b0;
            mdl_phase = P_DATA;
          end
        end
      end
      default: begin
        check("r_valid_gnt", rvalid[g], sl_valid);
        check("data_quiet", {arrdy, rvalid[og]}, 0);
        check("r_ready_s", s_if.RD_DATA_READY, m_rrdy[g]);
        if (rvalid[g] && m_rrdy[g]) begin
          rx_obs[g]++;
          sl_rx++;
        end
        if (sl_valid) begin
          check("r_payload", {rid[g], rdata[g], rresp[g], rlast[g]},
                {sl_req.id, exp_data, sl_resp, last});
          if (m_rrdy[g]) begin
            if (last ? (sl_idx != int'(sl_req.len)) : (sl_idx == int'(sl_req.len))) mdl_err = 1'b1;
            sl_idx++;
            sl_valid = 1'b0;
            if (last) begin
              check("burst_beats", sl_rx, sl_nbeats);
              sl_active = 1'b0;
              mdl_phase = P_IDLE;
            end
          end
        end
      end
    endcase
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((mdl_phase != P_IDLE || m_pend[0] || m_pend[1]) && n < budget) begin
      step();
      n++;
    end
    check("drain_done", {m_pend[0], m_pend[1], mdl_phase != P_IDLE}, 0);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  int base0, base1;

  initial begin
    rst = 1'b1;
    rrdy_pct    = '{100, 100};
    arrdy_pct   = 100;
    rvalid_pct  = 100;
    force_beats = 0;
    rx_obs      = '{0, 0};
    sl_idx      = 0;
    sl_nbeats   = 0;
    sl_rx       = 0;
    sl_resp     = RESP_OKAY;
    sl_req      = '0;
    m_req[0]    = '0;
    m_req[1]    = '0;
    m_rrdy      = '{1'b0, 1'b0};
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step();

    // Single M0 burst, LEN=3, data 0xA0..0xA3
    base0 = rx_obs[0];
    new_req(0, 8'd3, 32'h100, 32'hA0);
    drain(50);
    check("t1_m0_beats", rx_obs[0] - base0, 4);

    // Simultaneous requests after reset, twice
    do_reset();
    for (int r = 0; r < 2; r++) begin
      new_req(0, 8'($urandom_range(3)), $urandom, $urandom);
      new_req(1, 8'($urandom_range(3)), $urandom, $urandom);
      drain(100);
    end

    // M1 arrives during M0 DATA with R backpressure on M0
    rrdy_pct = '{40, 100};
    base0 = rx_obs[0];
    base1 = rx_obs[1];
    new_req(0, 8'd7, 32'h2000, 32'h5500);
    for (int n = 0; n < 20 && mdl_phase != P_DATA; n++) step();
    new_req(1, 8'd2, 32'h3000, 32'h6600);
    drain(200);
    check("t3_m0_beats", rx_obs[0] - base0, 8);
    check("t3_m1_beats", rx_obs[1] - base1, 3);

    // LEN boundaries
    rrdy_pct = '{100, 100};
    base1 = rx_obs[1];
    new_req(1, 8'd0, 32'h40, 32'h1000);
    drain(20);
    check("t4_len0_beats", rx_obs[1] - base1, 1);
    base1 = rx_obs[1];
    new_req(1, 8'd255, 32'h80, 32'h7700);
    drain(400);
    check("t4_len255_beats", rx_obs[1] - base1, 256);

    // Randomized traffic with backpressure everywhere
    rrdy_pct   = '{70, 60};
    arrdy_pct  = 60;
    rvalid_pct = 70;
    repeat (600) begin
      for (int i = 0; i < 2; i++)
        if (!m_pend[i] && $urandom_range(5) == 0)
          new_req(i, 8'($urandom_range(15)), $urandom, $urandom);
      step();
    end
    drain(2000);

    // Short burst: LAST on beat 2 of LEN=3, then a good burst
    force_beats = 2;
    new_req(0, 8'd3, 32'h500, 32'hB0);
    drain(100);
    force_beats = 0;
    base1 = rx_obs[1];
    new_req(1, 8'd3, 32'h600, 32'hC0);
    drain(100);
    check("t6_good_beats", rx_obs[1] - base1, 4);

    // Reset in the middle of DATA, then an M1-only request
    rrdy_pct   = '{100, 100};
    arrdy_pct  = 100;
    rvalid_pct = 100;
    new_req(0, 8'd15, 32'h700, 32'hD0);
    for (int n = 0; n < 40 && !(mdl_phase == P_DATA && sl_idx >= 3); n++) step();
    rst = 1'b1;
    #1;
    check("rst_quiet", {s_if.RD_ADDR_VALID, s_if.RD_DATA_READY, arrdy, rvalid}, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    base1 = rx_obs[1];
    new_req(1, 8'd2, 32'h800, 32'hE0);
    drain(50);
    check("t8_m1_beats", rx_obs[1] - base1, 3);

    // Long burst: 4 beats for LEN=1 flags the non-LAST beat at index LEN
    force_beats = 4;
    new_req(0, 8'd1, 32'h900, 32'hF0);
    drain(50);
    force_beats = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
